alu_seq_bcd: RTL and testbench
==============================

// Module: alu_seq_bcd
// PURPOSE
//  Parametrised successor of the CPU datapath ALU: WIDTH-bit logic/add/sub/shift
//  with per-nibble BCD correction on every nibble, plus an iterative unsigned
//  multiply/divide engine with a start/busy/done handshake. Used by wide math
//  coprocessor paths. Results and flags are registered; all state advances only when RDY=1.
// PARAMETERS
//  WIDTH      16  operand width, multiple of 4, range 8..32
//  BCD_EN     1   1 = BCD correction logic present; 0 = BCD input ignored
//  MULDIV_EN  1   1 = MUL/DIV engine present; 0 = ops 1000/1001 act as pass-A
// PORTS
//  clk      in   1      system clock, all state on rising edge
//  reset_n  in   1      asynchronous active-low reset
//  RDY      in   1      global stall; 0 freezes all state, including the done level
//  start    in   1      launch op; sampled only when RDY=1 and busy=0
//  op       in   4      operation code, see BEHAVIOUR
//  AI, BI   in   WIDTH  operands, sampled at the accepting edge
//  CI       in   1      carry in / shift-in bit
//  BCD      in   1      decimal mode for ADD/SUB
//  OUT      out  WIDTH  result (MUL low half, DIV quotient)
//  OUT_HI   out  WIDTH  MUL high half, DIV remainder, else 0
//  CO,V,Z,N,HC out 1    carry, overflow, zero, negative, half-carry flags
//  busy     out  1      multi-cycle op in progress
//  done     out  1      one-cycle pulse: OUT/flags valid for the accepted op
// BEHAVIOUR
//  Reset: FSM=IDLE, counter=0; OUT, OUT_HI, all flags, busy and done = 0.
//  Ops: 0000 A|B, 0001 A&B, 0010 A^B, 0011 A+B+CI, 0100 A+~B+CI (SUB, CI=1 = no borrow),
//   0101 shift left {A,CI} (CO=A[MSB]), 0110 rotate right {CI,A} (CO=A[0]), 0111 pass A,
//   1000 MUL unsigned, 1001 DIV unsigned, 1010-1111 reserved = pass A.
//  Single-cycle ops: accepting edge registers OUT/flags, done=1 for the next RDY cycle.
//  FSM IDLE -> ITER (MUL/DIV accepted) -> FIN -> IDLE. ITER runs exactly WIDTH
//   RDY-qualified cycles (shift-add / restoring shift-subtract, counter 0..WIDTH-1);
//   FIN registers the results; done=1 and busy=0 in the cycle after FIN.
//   Latency start->done: single-cycle ops 1, MUL/DIV WIDTH+2 RDY cycles.
//  busy=1 in ITER and FIN; start while busy=1 is ignored (no queueing).
//  start in the done cycle is accepted (back-to-back ops allowed).
//  Divide by zero: detected at accept, skips ITER: OUT=all ones, OUT_HI=AI, V=1,
//   done after 2 RDY cycles.
//  Arithmetic flags (ADD/SUB): CO = carry out of MSB after BCD adjust;
//   HC = carry out of nibble 0 after adjust; V = two's-complement overflow of the
//   uncorrected binary sum; N = OUT[WIDTH-1]; Z = (OUT == 0).
//  BCD=1 (BCD_EN=1): per nibble, low to high; ADD: if raw nibble sum > 9 or carried,
//   add 6 and carry 1 to next nibble; SUB: if nibble borrowed, subtract 6.
//   Operands with non-BCD nibbles give undefined OUT but defined flags rules.
//  Logic/shift/pass: V=0, HC=0, CO as listed (0 for logic/pass), N and Z from OUT.
//  MUL: CO = |OUT_HI, V=0. DIV: CO=0, V=0 unless divide by zero. Z,N from OUT.
//  RDY=0: FSM, counter, OUT, flags, done all held; a pending done pulse lasts until
//   the first RDY=1 cycle passes.
//  reset_n low mid-operation: immediate abort to reset state; no done is produced.
// TESTING (WIDTH=16)
//  ADD 0x7FFF+0x0001, CI=0, BCD=0 -> OUT=0x8000, V=1, N=1, CO=0, Z=0; done 1 cycle later.
//  BCD ADD 0x0999+0x0001 -> OUT=0x1000, HC=1, CO=0; 0x9999+0x0001 -> OUT=0x0000, CO=1, Z=1.
//  BCD SUB 0x1000-0x0001, CI=1 -> OUT=0x0999, CO=1; 0x0000-0x0001, CI=1 -> 0x9999, CO=0.
//  MUL 0x1234*0x0010 -> OUT=0x2340, OUT_HI=0x0001, CO=1, done at cycle 18; with RDY=0
//   for 3 cycles mid-ITER done at cycle 21; start pulsed while busy is ignored.
//  DIV 100/7 -> OUT=14, OUT_HI=2; DIV 0x1234/0 -> OUT=0xFFFF, OUT_HI=0x1234, V=1, done at 2.
//  reset_n low in ITER cycle 5 -> busy=0, done=0, OUT=0 at once; next start ADD 1+1 -> OUT=2.

Source files
------------

// File: rtl/alu_seq_bcd.sv
// alu_seq_bcd: WIDTH-bit ALU with per-nibble BCD correction and iterative unsigned MUL/DIV engine
module alu_seq_bcd #(
    parameter int WIDTH     = 16,
    parameter int BCD_EN    = 1,
    parameter int MULDIV_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RDY,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] AI,
    input  logic [WIDTH-1:0] BI,
    input  logic             CI,
    input  logic             BCD,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_HI,
    output logic             CO,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             HC,
    output logic             busy,
    output logic             done
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, mq, dvs;
    logic               is_div, dz;

    logic               is_sub, is_arith, bcd_mode, is_md, div_zero;
    logic [WIDTH-1:0]   bop, bres, sc_out, rem_n;
    logic [WIDTH:0]     bin, madd, dsh;
    logic [4:0]         ns;
    logic               nc, hc0, sc_co, sc_v, sc_hc, dge;
    logic [2*WIDTH-1:0] mul_step, div_step;

    always_comb begin
        is_sub   = op == 4'b0100;
        is_arith = (op == 4'b0011) || is_sub;
        bcd_mode = (BCD_EN != 0) && BCD;
        is_md    = (MULDIV_EN != 0) && (op[3:1] == 3'b100);
        div_zero = op[0] && (BI == '0);
        bop      = is_sub ? ~BI : BI;
        bin      = {1'b0, AI} + {1'b0, bop} + (WIDTH+1)'(CI);
        nc       = CI;
        ns       = '0;
        bres     = '0;
        hc0      = 1'b0;
        // Nibble-serial carry chain; decimal correction is applied before the carry propagates
        for (int i = 0; i < NIB; i++) begin
            ns = {1'b0, AI[4*i +: 4]} + {1'b0, bop[4*i +: 4]} + {4'b0, nc};
            if (bcd_mode && !is_sub) begin
                nc = ns > 5'd9;
                ns = nc ? ns + 5'd6 : ns;
            end else begin
                nc = ns[4];
                ns = (bcd_mode && !nc) ? ns - 5'd6 : ns;
            end
            bres[4*i +: 4] = ns[3:0];
            if (i == 0) hc0 = nc;
        end
        sc_out = (op == 4'b0000) ? AI | BI :
                 (op == 4'b0001) ? AI & BI :
                 (op == 4'b0010) ? AI ^ BI :
                 is_arith        ? (bcd_mode ? bres : bin[WIDTH-1:0]) :
                 (op == 4'b0101) ? {AI[WIDTH-2:0], CI} :
                 (op == 4'b0110) ? {CI, AI[WIDTH-1:1]} : AI;
        sc_co  = is_arith        ? (bcd_mode ? nc : bin[WIDTH]) :
                 (op == 4'b0101) ? AI[WIDTH-1] :
                 (op == 4'b0110) ? AI[0] : 1'b0;
        sc_v   = is_arith && (AI[WIDTH-1] == bop[WIDTH-1]) && (bin[WIDTH-1] != AI[WIDTH-1]);
        sc_hc  = is_arith && hc0;
        madd     = mq[0] ? {1'b0, acc} + {1'b0, dvs} : {1'b0, acc};
        mul_step = {madd, mq[WIDTH-1:1]};
        dsh      = {acc, mq[WIDTH-1]};
        dge      = dsh >= {1'b0, dvs};
        rem_n    = dge ? dsh[WIDTH-1:0] - dvs : dsh[WIDTH-1:0];
        div_step = {rem_n, mq[WIDTH-2:0], dge};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mq     <= '0;
            dvs    <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            OUT    <= '0;
            OUT_HI <= '0;
            CO     <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
            N      <= 1'b0;
            HC     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (RDY) begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (is_md) begin
                        is_div <= op[0];
                        dz     <= div_zero;
                        acc    <= div_zero ? AI : '0;
                        mq     <= div_zero ? '1 : (op[0] ? AI : BI);
                        dvs    <= op[0] ? BI : AI;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= div_zero ? FIN : ITER;
                    end else begin
                        OUT    <= sc_out;
                        OUT_HI <= '0;
                        CO     <= sc_co;
                        V      <= sc_v;
                        HC     <= sc_hc;
                        Z      <= sc_out == '0;
                        N      <= sc_out[WIDTH-1];
                        done   <= 1'b1;
                    end
                end
                ITER: begin
                    {acc, mq} <= is_div ? div_step : mul_step;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= FIN;
                end
                FIN: begin
                    OUT    <= mq;
                    OUT_HI <= acc;
                    CO     <= !is_div && (acc != '0);
                    V      <= dz;
                    HC     <= 1'b0;
                    Z      <= mq == '0;
                    N      <= mq[WIDTH-1];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_bcd.sv
// tb_alu_seq_bcd: randomized scoreboard bench for alu_seq_bcd at WIDTH=16
module tb_alu_seq_bcd;
    localparam int W = 16;

    logic         clk = 1'b0, reset_n = 1'b1, RDY = 1'b1, start = 1'b0, CI = 1'b0, BCD = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] AI = '0, BI = '0;
    logic [W-1:0] OUT, OUT_HI;
    logic         CO, V, Z, N, HC, busy, done;

    alu_seq_bcd #(.WIDTH(W), .BCD_EN(1), .MULDIV_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .op(op), .AI(AI), .BI(BI),
        .CI(CI), .BCD(BCD), .OUT(OUT), .OUT_HI(OUT_HI), .CO(CO), .V(V), .Z(Z), .N(N),
        .HC(HC), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic co, v, z, n, hc;
    } res_t;
    typedef struct {
        res_t       r;
        int         rc;
        logic [3:0] op;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0, bad = 0, rcnt = 0;
    bit   rnd_rdy = 1'b0;

    always @(posedge clk) if (RDY) rcnt <= rcnt + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic int dec(input logic [15:0] x);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] tobcd(input int x);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic res_t model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic d);
        res_t        r = '0;
        logic [15:0] bb;
        int          s;
        longint      p;
        bb = (o == 4'd4) ? ~b : b;
        case (o)
            4'd0: r.out = a | b;
            4'd1: r.out = a & b;
            4'd2: r.out = a ^ b;
            4'd3, 4'd4: begin
                s   = int'(a) + int'(bb) + int'(c);
                r.v = (a[15] == bb[15]) && (s[15] != a[15]);
                if (!d) begin
                    r.out = s[15:0];
                    r.co  = s[16];
                    r.hc  = (int'(a[3:0]) + int'(bb[3:0]) + int'(c)) > 15;
                end else if (o == 4'd3) begin
                    s     = dec(a) + dec(b) + int'(c);
                    r.out = tobcd(s % 10000);
                    r.co  = s >= 10000;
                    r.hc  = (int'(a[3:0]) + int'(b[3:0]) + int'(c)) > 9;
                end else begin
                    s     = dec(a) - dec(b) - 1 + int'(c);
                    r.out = tobcd(s < 0 ? s + 10000 : s);
                    r.co  = s >= 0;
                    r.hc  = (int'(a[3:0]) - int'(b[3:0]) - 1 + int'(c)) >= 0;
                end
            end
            4'd5: begin r.out = {a[14:0], c}; r.co = a[15]; end
            4'd6: begin r.out = {c, a[15:1]}; r.co = a[0]; end
            4'd8: begin
                p     = longint'(a) * longint'(b);
                r.out = p[15:0];
                r.hi  = p[31:16];
                r.co  = r.hi != 0;
            end
            4'd9: begin
                if (b == 0) begin r.out = 16'hFFFF; r.hi = a; r.v = 1'b1; end
                else begin r.out = a / b; r.hi = a % b; end
            end
            default: r.out = a;
        endcase
        r.z = r.out == 0;
        r.n = r.out[15];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic d);
        int guard = 0;
        int lat;
        if (rnd_rdy && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin
                RDY = 1'($urandom_range(0, 1));
                start = 1'b0;
                tick();
            end
        while (busy && guard < 200) begin
            RDY   = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = rnd_rdy && ($urandom_range(0, 3) == 0);
            op    = 4'($urandom);
            AI    = 16'($urandom);
            BI    = 16'($urandom);
            tick();
            guard++;
        end
        if (busy) chk("busy_timeout", 64'(busy), 64'd0);
        lat = (o == 4'd8) ? 18 : (o == 4'd9) ? ((b == 0) ? 2 : 18) : 1;
        op = o; AI = a; BI = b; CI = c; BCD = d; start = 1'b1; RDY = 1'b1;
        q.push_back('{model(o, a, b, c, d), rcnt + lat, o});
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 300) begin
            RDY = 1'b1;
            start = 1'b0;
            tick();
            guard++;
        end
        chk("drain_queue_left", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n && RDY && done) begin
            if (q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk($sformatf("result op=%0h", e.op), {27'b0, OUT, OUT_HI, CO, V, Z, N, HC}, {27'b0, e.r});
                chk($sformatf("latency op=%0h", e.op), 64'(rcnt), 64'(e.rc));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        logic [3:0]  o;
        logic [15:0] a, b;
        logic        c, d;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        chk("reset_out", {32'b0, OUT, OUT_HI}, 64'd0);
        chk("reset_flags", {57'b0, CO, V, Z, N, HC, busy, done}, 64'd0);
        #3 reset_n = 1'b1;
        tick();

        issue(4'd3, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(4'd3, 16'h0999, 16'h0001, 1'b0, 1'b1);
        issue(4'd3, 16'h9999, 16'h0001, 1'b0, 1'b1);
        issue(4'd4, 16'h1000, 16'h0001, 1'b1, 1'b1);
        issue(4'd4, 16'h0000, 16'h0001, 1'b1, 1'b1);
        issue(4'd8, 16'h1234, 16'h0010, 1'b0, 1'b0);
        issue(4'd8, 16'h1234, 16'h0010, 1'b0, 1'b0);
        op = 4'd3; AI = 16'd1; BI = 16'd1; start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        repeat (3) tick();
        RDY = 1'b0;
        repeat (3) tick();
        RDY = 1'b1;
        issue(4'd9, 16'd100, 16'd7, 1'b0, 1'b0);
        issue(4'd9, 16'h1234, 16'h0000, 1'b0, 1'b0);
        issue(4'd5, 16'h8001, 16'h0000, 1'b1, 1'b0);
        issue(4'd6, 16'h0001, 16'h0000, 1'b1, 1'b0);
        drain();

        rnd_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            o = 4'($urandom_range(0, 15));
            c = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            if (d && (o == 4'd3 || o == 4'd4)) begin
                a = tobcd($urandom_range(0, 9999));
                b = tobcd($urandom_range(0, 9999));
            end
            if (o == 4'd9 && $urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 20));
            issue(o, a, b, c, d);
        end
        rnd_rdy = 1'b0;
        drain();

        issue(4'd3, 16'd5, 16'd5, 1'b0, 1'b0);
        drain();
        issue(4'd8, 16'h00FF, 16'h0101, 1'b0, 1'b0);
        repeat (4) tick();
        #3 reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_out", {32'b0, OUT, OUT_HI}, 64'd0);
        q.delete();
        repeat (2) tick();
        #3 reset_n = 1'b1;
        tick();
        issue(4'd3, 16'd1, 16'd1, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
